// File: rtl/rom_arbiter.sv
// rom_arbiter: two-port arbiter and access sequencer for a shared combinational code ROM.
// Each requester issues single-word reads. The winner's address is registered onto
// rom_addr and held for WAIT_CYC cycles. The ROM code is then captured into that
// port's data register and acknowledged with a one-cycle pulse.
// Optional build macro: ROM_ARB_FIXED_PRI_EN selects fixed priority (port 0 wins ties).
// Without it, ties are resolved round robin.
//
//  state | meaning
//  IDLE  | waiting for a request; rom_addr holds its last value
//  SERVE | rom_addr driven, settle counter running
//  ACK   | code captured, ack pulse of the granted port is high
module rom_arbiter #(
  parameter int AW       = 5,
  parameter int DW       = 8,
  parameter int WAIT_CYC = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  output logic          ack0,
  output logic [DW-1:0] data0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  output logic          ack1,
  output logic [DW-1:0] data1,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_code,
  output logic          busy
);

  localparam int CW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          gnt;
  logic          win;
  logic          any_req;
  logic          settle_done;

`ifndef ROM_ARB_FIXED_PRI_EN
  logic          last_grant;
`endif

  // Winner selection for the current IDLE cycle
  always_comb begin
    any_req = req0 | req1;
`ifdef ROM_ARB_FIXED_PRI_EN
    win = ~req0;
`else
    if (req0 && req1) win = ~last_grant;
    else              win = req1;
`endif
  end

  assign settle_done = (cnt == CW'(WAIT_CYC - 1));
  assign busy        = (state != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = SERVE;
      SERVE:   if (settle_done) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: address latch, settle counter, data capture and ack pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr   <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      data0      <= '0;
      data1      <= '0;
      gnt        <= 1'b0;
      cnt        <= '0;
`ifndef ROM_ARB_FIXED_PRI_EN
      last_grant <= 1'b1;
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt      <= win;
            rom_addr <= win ? addr1 : addr0;
            cnt      <= '0;
          end
        end
        SERVE: begin
          if (settle_done) begin
            if (gnt) begin
              data1 <= rom_code;
              ack1  <= 1'b1;
            end else begin
              data0 <= rom_code;
              ack0  <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ACK: begin
`ifndef ROM_ARB_FIXED_PRI_EN
          last_grant <= gnt;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: two instances (WAIT_CYC=1 and WAIT_CYC=3) share one stimulus.
// A transaction-level model predicts every output on every cycle. Directed sequences
// pin known literal results.
module tb_rom_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [4:0] addr0 = '0, addr1 = '0;

  logic [1:0] ack0_v, ack1_v, busy_v;
  logic [7:0] data0_v [2];
  logic [7:0] data1_v [2];
  logic [4:0] rom_addr_v [2];
  logic [7:0] rom_code_v [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign rom_code_v[0] = {3'b101, rom_addr_v[0]};
  assign rom_code_v[1] = {3'b101, rom_addr_v[1]};

  rom_arbiter #(.AW(5), .DW(8), .WAIT_CYC(1)) dut_a (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .ack0(ack0_v[0]), .data0(data0_v[0]),
    .req1(req1), .addr1(addr1), .ack1(ack1_v[0]), .data1(data1_v[0]),
    .rom_addr(rom_addr_v[0]), .rom_code(rom_code_v[0]), .busy(busy_v[0])
  );

  rom_arbiter #(.AW(5), .DW(8), .WAIT_CYC(3)) dut_b (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .ack0(ack0_v[1]), .data0(data0_v[1]),
    .req1(req1), .addr1(addr1), .ack1(ack1_v[1]), .data1(data1_v[1]),
    .rom_addr(rom_addr_v[1]), .rom_code(rom_code_v[1]), .busy(busy_v[1])
  );

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, idx, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Inputs as seen by the DUTs at each rising edge
  logic       s_rst = 1'b1, s_req0 = 1'b0, s_req1 = 1'b0;
  logic [4:0] s_addr0 = '0, s_addr1 = '0;
  always @(posedge clk) begin
    s_rst   <= rst;
    s_req0  <= req0;
    s_req1  <= req1;
    s_addr0 <= addr0;
    s_addr1 <= addr1;
  end

  // Transaction model: one access occupies WAIT_CYC+2 cycles starting at the IDLE
  // cycle in which it is granted. The ack lands WAIT_CYC+1 cycles after that cycle.
  int         w_of [2] = '{1, 3};
  int         idle_at [2];
  int         ack_cyc [2];
  bit         pend [2];
  bit         mg [2];
  bit         last [2];
  logic [4:0] pa [2];
  bit         e_ack0 [2], e_ack1 [2];
  logic [7:0] e_data0 [2], e_data1 [2];
  logic [4:0] e_rom [2];

  initial begin
    int m;
    m = 0;
    forever begin
      @(negedge clk);
      m++;
      for (int i = 0; i < 2; i++) begin
        if (s_rst) begin
          idle_at[i] = m;
          pend[i]    = 0;
          last[i]    = 1;
          e_ack0[i]  = 0;
          e_ack1[i]  = 0;
          e_data0[i] = '0;
          e_data1[i] = '0;
          e_rom[i]   = '0;
        end else begin
          e_ack0[i] = 0;
          e_ack1[i] = 0;
          if (pend[i] && m == ack_cyc[i]) begin
            if (mg[i]) begin e_ack1[i] = 1; e_data1[i] = {3'b101, pa[i]}; end
            else       begin e_ack0[i] = 1; e_data0[i] = {3'b101, pa[i]}; end
            pend[i] = 0;
          end
          if ((m - 1) >= idle_at[i] && (s_req0 || s_req1)) begin
`ifdef ROM_ARB_FIXED_PRI_EN
            mg[i] = !s_req0;
`else
            mg[i] = (s_req0 && s_req1) ? !last[i] : s_req1;
`endif
            last[i]    = mg[i];
            pa[i]      = mg[i] ? s_addr1 : s_addr0;
            e_rom[i]   = pa[i];
            ack_cyc[i] = m + w_of[i];
            idle_at[i] = m + w_of[i] + 1;
            pend[i]    = 1;
          end
        end
        chk("m_ack0", i, 32'(ack0_v[i]), 32'(e_ack0[i]));
        chk("m_ack1", i, 32'(ack1_v[i]), 32'(e_ack1[i]));
        chk("m_data0", i, 32'(data0_v[i]), 32'(e_data0[i]));
        chk("m_data1", i, 32'(data1_v[i]), 32'(e_data1[i]));
        chk("m_rom_addr", i, 32'(rom_addr_v[i]), 32'(e_rom[i]));
        chk("m_busy", i, 32'(busy_v[i]), 32'(m < idle_at[i]));
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    int n_ack0;
    int ack_port [$];
    int ack_at [$];

    // Reset values
    do_reset();
    @(negedge clk);
    chk("rst_busy", 0, 32'(busy_v[0]), 32'd0);
    chk("rst_rom_addr", 0, 32'(rom_addr_v[0]), 32'd0);
    chk("rst_data0", 0, 32'(data0_v[0]), 32'd0);
    chk("rst_ack", 0, 32'({ack0_v[0], ack1_v[0]}), 32'd0);

    // Single request on port 0
    req0 = 1'b1; addr0 = 5'd3;
    step(); @(negedge clk);
    chk("t1_ack0_early", 0, 32'(ack0_v[0]), 32'd0);
    chk("t1_busy", 0, 32'(busy_v[0]), 32'd1);
    step(); @(negedge clk);
    chk("t1_ack0", 0, 32'(ack0_v[0]), 32'd1);
    chk("t1_data0", 0, 32'(data0_v[0]), 32'hA3);
    chk("t1_ack1", 0, 32'(ack1_v[0]), 32'd0);
    req0 = 1'b0;

    // Simultaneous requests: port 0 first, port 1 three cycles later
    do_reset();
    req0 = 1'b1; addr0 = 5'd2; req1 = 1'b1; addr1 = 5'd7;
    step(); step(); @(negedge clk);
    chk("t2_ack0", 0, 32'(ack0_v[0]), 32'd1);
    chk("t2_data0", 0, 32'(data0_v[0]), 32'hA2);
    req0 = 1'b0;
    step(); step(); step(); @(negedge clk);
    chk("t2_ack1", 0, 32'(ack1_v[0]), 32'd1);
    chk("t2_data1", 0, 32'(data1_v[0]), 32'hA7);
    chk("t2_ack0_off", 0, 32'(ack0_v[0]), 32'd0);
    req1 = 1'b0;

`ifdef ROM_ARB_FIXED_PRI_EN
    // Both held: only port 0 is served; dropping req0 lets port 1 in
    do_reset();
    req0 = 1'b1; addr0 = 5'd1; req1 = 1'b1; addr1 = 5'd2;
    n_ack0 = 0;
    for (int k = 1; k <= 8; k++) begin
      step(); @(negedge clk);
      chk("t6_no_ack1", 0, 32'(ack1_v[0]), 32'd0);
      if (ack0_v[0]) n_ack0++;
    end
    chk("t6_ack0_count", 0, 32'(n_ack0), 32'd3);
    req0 = 1'b0;
    step(); step(); step(); @(negedge clk);
    chk("t6_ack1", 0, 32'(ack1_v[0]), 32'd1);
    chk("t6_data1", 0, 32'(data1_v[0]), 32'hA2);
    req1 = 1'b0;
`else
    // Both held for 12 cycles: acks alternate 0,1,0,1 every 3 cycles
    do_reset();
    req0 = 1'b1; addr0 = 5'd1; req1 = 1'b1; addr1 = 5'd2;
    for (int k = 1; k <= 12; k++) begin
      step(); @(negedge clk);
      if (ack0_v[0]) begin ack_port.push_back(0); ack_at.push_back(k); end
      if (ack1_v[0]) begin ack_port.push_back(1); ack_at.push_back(k); end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("t3_ack_count", 0, 32'(ack_port.size()), 32'd4);
    for (int j = 0; j < 4 && j < ack_port.size(); j++) begin
      chk("t3_ack_port", 0, 32'(ack_port[j]), 32'(j % 2));
      chk("t3_ack_cycle", 0, 32'(ack_at[j]), 32'(2 + 3 * j));
    end
`endif

    // Long settle window (WAIT_CYC=3 instance); address change after grant ignored
    do_reset();
    req1 = 1'b1; addr1 = 5'd31;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 2) addr1 = 5'd9;
      @(negedge clk);
      if (k < 4) begin
        chk("t4_rom_addr", 1, 32'(rom_addr_v[1]), 32'd31);
        chk("t4_ack1_early", 1, 32'(ack1_v[1]), 32'd0);
      end else begin
        chk("t4_ack1", 1, 32'(ack1_v[1]), 32'd1);
        chk("t4_data1", 1, 32'(data1_v[1]), 32'hBF);
      end
    end
    req1 = 1'b0;

    // Reset during SERVE aborts silently; the next request runs normally
    do_reset();
    req0 = 1'b1; addr0 = 5'd3;
    step(); step(); req0 = 1'b0;
    step();
    req0 = 1'b1; addr0 = 5'd4;
    step(); @(negedge clk);
    chk("t5_serve_addr", 0, 32'(rom_addr_v[0]), 32'd4);
    rst = 1'b1; req0 = 1'b0;
    step(); @(negedge clk);
    chk("t5_no_ack", 0, 32'(ack0_v[0]), 32'd0);
    chk("t5_data0", 0, 32'(data0_v[0]), 32'd0);
    chk("t5_rom_addr", 0, 32'(rom_addr_v[0]), 32'd0);
    chk("t5_busy", 0, 32'(busy_v[0]), 32'd0);
    rst = 1'b0; req0 = 1'b1; addr0 = 5'd5;
    step(); step(); @(negedge clk);
    chk("t5_ack0", 0, 32'(ack0_v[0]), 32'd1);
    chk("t5_data0_after", 0, 32'(data0_v[0]), 32'hA5);
    req0 = 1'b0;

    // Random traffic, including occasional resets, checked by the model
    for (int n = 0; n < 3000; n++) begin
      step();
      rst   = ($urandom_range(0, 59) == 0);
      req0  = ($urandom_range(0, 3) != 0);
      req1  = ($urandom_range(0, 3) != 0);
      addr0 = 5'($urandom);
      addr1 = 5'($urandom);
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    for (int n = 0; n < 8; n++) step();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
